div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle iterative integer divider for the RV32M DIV/DIVU/REM/REMU ops.
//  It is the inverse-operation partner of the single-cycle ALU. It sits beside
//  the ALU in EX: the pipeline stalls on div_busy_o and takes the result on the
//  div_valid_o pulse. Radix-2 restoring algorithm, one quotient bit per cycle.
// PARAMETERS
//  DATA_WIDTH  32   operand/result width; must be >= 2
//  CNT_WIDTH   5    iteration counter width, $clog2(DATA_WIDTH)
// PORTS
//  clk_i           in   1           clock, all state on rising edge
//  rst_i           in   1           synchronous reset, active-high
//  div_start_i     in   1           request; sampled only in IDLE
//  div_op_i        in   2           00 DIV, 01 DIVU, 10 REM, 11 REMU
//  div_dividend_i  in   DATA_WIDTH  rs1 value, sampled with start
//  div_divisor_i   in   DATA_WIDTH  rs2 value, sampled with start
//  div_flush_i     in   1           abort current operation (pipeline flush)
//  div_busy_o      out  1           1 when state != IDLE
//  div_valid_o     out  1           1-cycle pulse, result_o valid this cycle
//  div_result_o    out  DATA_WIDTH  quotient or remainder per latched op
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, div_busy_o=0, div_valid_o=0, div_result_o=0; internal regs cleared.
//  FSM: IDLE, CALC, DONE.
//   IDLE, start=1, divisor!=0: latch op and |operands|, record signs, count=0 -> CALC.
//    Magnitudes are used for DIV/REM only; DIVU/REMU take raw operands.
//   IDLE, start=1, divisor==0: -> DONE directly. Quotient=all ones; remainder=dividend.
//   CALC: rem={rem,quot[MSB]}-divisor when >=0, else restore; shift in q bit; count++.
//    The cycle with count==DATA_WIDTH-1 -> DONE.
//   DONE: div_valid_o=1; result_o driven from final regs -> IDLE next cycle.
//  Latency: start sampled in cycle T -> CALC T+1..T+DATA_WIDTH -> valid in T+DATA_WIDTH+1 (T+33).
//   For a zero divisor, valid is in T+1.
//  Sign fix-up (signed ops): quotient negated iff dividend and divisor signs differ.
//   Remainder takes the sign of the dividend.
//  Overflow: DIV -2^31/-1 = 0x80000000; REM gives 0. Both come from the normal path,
//   with no special case.
//  div_result_o holds its last value between valid pulses; it changes only in DONE.
//  start while busy (CALC or DONE): ignored, not queued; inputs may change freely.
//  Flush: from any state, next state = IDLE, no valid pulse, result_o unchanged.
//   Flush and start in the same IDLE cycle: flush wins, nothing starts.
//  Reset mid-operation: returns to IDLE next edge; the operation is lost.
//  div_op_i is latched at start; later input changes do not affect the result.
// TESTING
//  1 DIVU 100/7: start@T -> busy T+1..T+33, valid@T+33, result=14; REMU same -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//  3 Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REM -5/0 -> 0xFFFFFFFB.
//    Both: valid@T+1, busy only in T+1.
//  4 Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5 Start DIVU 9/3, then start again at T+5 with different operands (ignored):
//    valid@T+33 with 3. Flush at T+10 of a new op -> IDLE@T+11, no valid,
//    result_o still 3.
//  6 rst_i at T+15 mid-CALC -> busy=0, valid=0, result=0 next cycle.
//    A new start is accepted immediately after.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring integer divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and pulses div_valid_o when the result is ready.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  div_start_i,
    input  logic [1:0]            div_op_i,
    input  logic [DATA_WIDTH-1:0] div_dividend_i,
    input  logic [DATA_WIDTH-1:0] div_divisor_i,
    input  logic                  div_flush_i,
    output logic                  div_busy_o,
    output logic                  div_valid_o,
    output logic [DATA_WIDTH-1:0] div_result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quot;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_rem_sel;
    logic                  r_neg_q;
    logic                  r_neg_r;

    // Operand conditioning at start: signed ops work on magnitudes.
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_div_zero;

    assign w_signed   = ~div_op_i[0];
    assign w_a_neg    = w_signed & div_dividend_i[DATA_WIDTH-1];
    assign w_b_neg    = w_signed & div_divisor_i[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? (DATA_WIDTH'(0) - div_dividend_i) : div_dividend_i;
    assign w_b_mag    = w_b_neg ? (DATA_WIDTH'(0) - div_divisor_i) : div_divisor_i;
    assign w_div_zero = (div_divisor_i == '0);

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quot_next;
    logic [DATA_WIDTH-1:0] w_quot_fix;
    logic [DATA_WIDTH-1:0] w_rem_fix;

    assign w_shift     = {r_rem, r_quot[DATA_WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_take      = ~w_diff[DATA_WIDTH];
    assign w_rem_next  = w_take ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_quot_next = {r_quot[DATA_WIDTH-2:0], w_take};
    assign w_quot_fix  = r_neg_q ? (DATA_WIDTH'(0) - w_quot_next) : w_quot_next;
    assign w_rem_fix   = r_neg_r ? (DATA_WIDTH'(0) - w_rem_next) : w_rem_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (div_flush_i) begin
            // Abort leaves the last delivered result untouched.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (div_start_i) begin
                        r_rem_sel <= div_op_i[1];
                        r_busy    <= 1'b1;
                        if (w_div_zero) begin
                            r_result <= div_op_i[1] ? div_dividend_i : '1;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_rem     <= '0;
                            r_quot    <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_count   <= '0;
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + CNT_WIDTH'(1);
                    if (r_count == LAST_CNT) begin
                        r_result <= r_rem_sel ? w_rem_fix : w_quot_fix;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_busy_o   = r_busy;
    assign div_valid_o  = r_valid;
    assign div_result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// overflow, start-while-busy, flush and mid-operation reset.
module tb_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        div_start_i;
    logic [1:0]  div_op_i;
    logic [31:0] div_dividend_i;
    logic [31:0] div_divisor_i;
    logic        div_flush_i;
    logic        div_busy_o;
    logic        div_valid_o;
    logic [31:0] div_result_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .div_start_i    (div_start_i),
        .div_op_i       (div_op_i),
        .div_dividend_i (div_dividend_i),
        .div_divisor_i  (div_divisor_i),
        .div_flush_i    (div_flush_i),
        .div_busy_o     (div_busy_o),
        .div_valid_o    (div_valid_o),
        .div_result_o   (div_result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one operation from IDLE, scrambles the inputs after the start cycle,
    // and reports the cycle of the valid pulse relative to the start cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output bit busy_ok);
        div_start_i    = 1'b1;
        div_op_i       = op;
        div_dividend_i = a;
        div_divisor_i  = b;
        step();
        div_start_i    = 1'b0;
        div_op_i       = ~op;
        div_dividend_i = ~a;
        div_divisor_i  = b + 32'd1;
        lat     = 1;
        busy_ok = 1'b1;
        while (div_valid_o !== 1'b1 && lat < 40) begin
            if (div_busy_o !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (div_busy_o !== 1'b1) busy_ok = 1'b0;
        res = div_result_o;
        step();
        if (div_busy_o !== 1'b0 || div_valid_o !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        div_op_i = 2'b00;
        div_dividend_i = '0;
        div_divisor_i = '0;
        step();
        step();
        rst_i = 1'b0;
        n_cmp++;
        if (div_busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", div_busy_o);
        end
        n_cmp++;
        if (div_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", div_valid_o);
        end
        n_cmp++;
        if (div_result_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 00000000", div_result_o);
        end
        step();
        $display("reset: busy=%b valid=%b result=%h", div_busy_o, div_valid_o, div_result_o);
    endtask

    task automatic test_unsigned();
        int lat;
        logic [31:0] res;
        bit ok;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, res, ok);
        $display("DIVU 100/7 -> %h lat=%0d", res, lat);
        n_cmp++;
        if (res !== 32'd14) begin n_bad++; $display("FAIL divu_result: got %h want 0000000e", res); end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL divu_busy: got busy profile bad want busy T+1..T+33"); end
        run_op(OP_REMU, 32'd100, 32'd7, lat, res, ok);
        $display("REMU 100/7 -> %h lat=%0d", res, lat);
        n_cmp++;
        if (res !== 32'd2) begin n_bad++; $display("FAIL remu_result: got %h want 00000002", res); end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL remu_latency: got %0d want 33", lat); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] res;
        bit ok;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, ok);
        $display("DIV -7/2 -> %h", res);
        n_cmp++;
        if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg: got %h want fffffffd", res); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res, ok);
        $display("REM -7/2 -> %h", res);
        n_cmp++;
        if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rem_neg_dividend: got %h want ffffffff", res); end
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res, ok);
        $display("REM 7/-2 -> %h", res);
        n_cmp++;
        if (res !== 32'd1) begin n_bad++; $display("FAIL rem_neg_divisor: got %h want 00000001", res); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, ok);
        $display("DIV 7/-2 -> %h", res);
        n_cmp++;
        if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_divisor: got %h want fffffffd", res); end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] res;
        bit ok;
        run_op(OP_DIVU, 32'd5, 32'd0, lat, res, ok);
        $display("DIVU 5/0 -> %h lat=%0d", res, lat);
        n_cmp++;
        if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_result: got %h want ffffffff", res); end
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL divz_latency: got %0d want 1", lat); end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL divz_busy: got busy profile bad want busy only T+1"); end
        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, lat, res, ok);
        $display("REM -5/0 -> %h lat=%0d", res, lat);
        n_cmp++;
        if (res !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL remz_result: got %h want fffffffb", res); end
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL remz_latency: got %0d want 1", lat); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] res;
        bit ok;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
        $display("DIV 80000000/ffffffff -> %h", res);
        n_cmp++;
        if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_div: got %h want 80000000", res); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, ok);
        $display("REM 80000000/ffffffff -> %h", res);
        n_cmp++;
        if (res !== 32'h0) begin n_bad++; $display("FAIL ovf_rem: got %h want 00000000", res); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        div_start_i    = 1'b1;
        div_op_i       = OP_DIVU;
        div_dividend_i = 32'd9;
        div_divisor_i  = 32'd3;
        step();
        div_start_i = 1'b0;
        lat = 1;
        while (div_valid_o !== 1'b1 && lat < 40) begin
            if (lat == 5) begin
                div_start_i    = 1'b1;
                div_op_i       = OP_REM;
                div_dividend_i = 32'd100;
                div_divisor_i  = 32'd10;
            end else begin
                div_start_i = 1'b0;
            end
            step();
            lat++;
        end
        div_start_i = 1'b0;
        $display("DIVU 9/3 with restart at T+5 -> %h lat=%0d", div_result_o, lat);
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        n_cmp++;
        if (div_result_o !== 32'd3) begin n_bad++; $display("FAIL ignore_result: got %h want 00000003", div_result_o); end
        step();
    endtask

    task automatic test_flush();
        int pulses;
        div_start_i    = 1'b1;
        div_op_i       = OP_DIVU;
        div_dividend_i = 32'd50;
        div_divisor_i  = 32'd5;
        step();
        div_start_i = 1'b0;
        for (int i = 1; i < 10; i++) step();
        div_flush_i = 1'b1;
        step();
        div_flush_i = 1'b0;
        $display("flush at T+10: busy=%b valid=%b result=%h", div_busy_o, div_valid_o, div_result_o);
        n_cmp++;
        if (div_busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", div_busy_o); end
        n_cmp++;
        if (div_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", div_valid_o); end
        n_cmp++;
        if (div_result_o !== 32'd3) begin n_bad++; $display("FAIL flush_result: got %h want 00000003", div_result_o); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_valid_o === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d pulses want 0", pulses); end
        div_start_i = 1'b1;
        div_flush_i = 1'b1;
        step();
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        $display("flush+start: busy=%b", div_busy_o);
        n_cmp++;
        if (div_busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_start: got busy %b want 0", div_busy_o); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        bit ok;
        div_start_i    = 1'b1;
        div_op_i       = OP_DIVU;
        div_dividend_i = 32'd1000;
        div_divisor_i  = 32'd10;
        step();
        div_start_i = 1'b0;
        for (int i = 1; i < 15; i++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        $display("reset at T+15: busy=%b valid=%b result=%h", div_busy_o, div_valid_o, div_result_o);
        n_cmp++;
        if (div_busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", div_busy_o); end
        n_cmp++;
        if (div_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", div_valid_o); end
        n_cmp++;
        if (div_result_o !== 32'h0) begin n_bad++; $display("FAIL midrst_result: got %h want 00000000", div_result_o); end
        run_op(OP_DIVU, 32'd1000, 32'd10, lat, res, ok);
        $display("DIVU 1000/10 after reset -> %h lat=%0d", res, lat);
        n_cmp++;
        if (res !== 32'd100) begin n_bad++; $display("FAIL midrst_restart: got %h want 00000064", res); end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL midrst_latency: got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
